// File: rtl/piso_pkg.sv
// Shared constants for the 3-stage PISO serializer: width, default reset vector, mode encodings.
package piso_pkg;

    localparam int unsigned PISO_W = 3;

    localparam logic [PISO_W-1:0] PISO_RST_DEFAULT = 3'b000;

    localparam logic PISO_LOAD  = 1'b0;
    localparam logic PISO_SHIFT = 1'b1;

endpackage

// File: rtl/piso3_shift_reg_if.sv
// Data/control bundle for piso3_shift_reg; `done` exists only when PISO_DONE_FLAG_EN is defined.
interface piso3_shift_reg_if;

    logic shift;
    logic si;
    logic pa;
    logic pb;
    logic pc;
    logic qa;
    logic qb;
    logic so;
`ifdef PISO_DONE_FLAG_EN
    logic done;

    modport master (output shift, si, pa, pb, pc, input qa, qb, so, done);
    modport slave  (input shift, si, pa, pb, pc, output qa, qb, so, done);
`else
    modport master (output shift, si, pa, pb, pc, input qa, qb, so);
    modport slave  (input shift, si, pa, pb, pc, output qa, qb, so);
`endif

endinterface

// File: rtl/piso_stage.sv
// One serializer stage: a flop fed by a load/shift 2:1 mux with synchronous reset.
module piso_stage
    import piso_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic sel,
    input  logic par_in,
    input  logic ser_in,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= rst_val;
        end else begin
            case (sel)
                PISO_LOAD:  q <= par_in;
                PISO_SHIFT: q <= ser_in;
                default:    q <= par_in;
            endcase
        end
    end

endmodule

// File: rtl/piso3_shift_reg.sv
// 3-stage parallel-in/serial-out shift register (A->B->C, C drives so).
// Optional PISO_DONE_FLAG_EN adds a registered `done` after three shifts since the last load/reset.
module piso3_shift_reg
    import piso_pkg::*;
#(
    parameter logic [PISO_W-1:0] RST_VAL = PISO_RST_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    piso3_shift_reg_if.slave   bus
);

    logic qa_q;
    logic qb_q;
    logic qc_q;

    piso_stage u_stage_a (
        .clk     (clk),
        .rst     (rst),
        .rst_val (RST_VAL[2]),
        .sel     (bus.shift),
        .par_in  (bus.pa),
        .ser_in  (bus.si),
        .q       (qa_q)
    );

    piso_stage u_stage_b (
        .clk     (clk),
        .rst     (rst),
        .rst_val (RST_VAL[1]),
        .sel     (bus.shift),
        .par_in  (bus.pb),
        .ser_in  (qa_q),
        .q       (qb_q)
    );

    piso_stage u_stage_c (
        .clk     (clk),
        .rst     (rst),
        .rst_val (RST_VAL[0]),
        .sel     (bus.shift),
        .par_in  (bus.pc),
        .ser_in  (qb_q),
        .q       (qc_q)
    );

    assign bus.qa = qa_q;
    assign bus.qb = qb_q;
    assign bus.so = qc_q;

`ifdef PISO_DONE_FLAG_EN
    logic [1:0] shift_cnt;
    logic       done_q;

    // done is registered alongside the counter: it rises on the edge the counter reaches 3.
    always_ff @(posedge clk) begin
        if (rst || (bus.shift == PISO_LOAD)) begin
            shift_cnt <= '0;
            done_q    <= 1'b0;
        end else begin
            if (shift_cnt != 2'd3) begin
                shift_cnt <= shift_cnt + 2'd1;
            end
            done_q <= (shift_cnt >= 2'd2);
        end
    end

    assign bus.done = done_q;
`endif

endmodule

// File: tb/tb_piso3_shift_reg.sv
// Self-checking bench for piso3_shift_reg: directed literal checks plus randomized traffic against a behavioural model.
module tb_piso3_shift_reg;

    logic clk;
    logic rst;

    int tests;
    int fails;

    piso3_shift_reg_if bus ();

    piso3_shift_reg #(.RST_VAL(3'b000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: contents as a 3-bit number {A,B,C}; shifting moves bits toward C (lsb), si enters at A.
    logic [2:0] m_val;
    int         m_shifts;
    bit         m_valid;

    initial begin
        m_val    = 3'b000;
        m_shifts = 0;
        m_valid  = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_val    = 3'b000;
            m_shifts = 0;
            m_valid  = 1'b1;
        end else if (!bus.shift) begin
            m_val    = {bus.pa, bus.pb, bus.pc};
            m_shifts = 0;
        end else begin
            m_val    = (m_val >> 1) | (3'(bus.si) << 2);
            m_shifts = m_shifts + 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            tests++;
            if ({bus.qa, bus.qb, bus.so} !== m_val) begin
                fails++;
                $display("FAIL model_cmp t=%0t: got {qa,qb,so}=%b expected %b", $time, {bus.qa, bus.qb, bus.so}, m_val);
            end
`ifdef PISO_DONE_FLAG_EN
            tests++;
            if (bus.done !== (m_shifts >= 3)) begin
                fails++;
                $display("FAIL model_done t=%0t: got done=%b expected %b", $time, bus.done, (m_shifts >= 3));
            end
`endif
        end
    end

    task automatic drive(input logic r, input logic sh, input logic s,
                         input logic a, input logic b, input logic c);
        rst       = r;
        bus.shift = sh;
        bus.si    = s;
        bus.pa    = a;
        bus.pb    = b;
        bus.pc    = c;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [2:0] exp);
        tests++;
        if ({bus.qa, bus.qb, bus.so} !== exp) begin
            fails++;
            $display("FAIL %s: got {qa,qb,so}=%b expected %b", name, {bus.qa, bus.qb, bus.so}, exp);
        end
    endtask

`ifdef PISO_DONE_FLAG_EN
    task automatic chk_done(input string name, input logic exp);
        tests++;
        if (bus.done !== exp) begin
            fails++;
            $display("FAIL %s: got done=%b expected %b", name, bus.done, exp);
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;

        // Reset with all parallel inputs high
        drive(1, 0, 0, 1, 1, 1);
        drive(1, 0, 0, 1, 1, 1);
        chk("reset", 3'b000);
`ifdef PISO_DONE_FLAG_EN
        chk_done("reset_done", 1'b0);
`endif

        // Parallel load 101 and hold
        drive(0, 0, 0, 1, 0, 1);
        chk("load101", 3'b101);
        drive(0, 0, 0, 1, 0, 1);
        drive(0, 0, 0, 1, 0, 1);
        chk("load101_hold", 3'b101);

        // Shift out with si=0
        drive(0, 1, 0, 0, 0, 0);
        chk("shift1", 3'b010);
        drive(0, 1, 0, 0, 0, 0);
        chk("shift2", 3'b001);
        drive(0, 1, 0, 0, 0, 0);
        chk("shift3", 3'b000);
`ifdef PISO_DONE_FLAG_EN
        chk_done("done_after3", 1'b1);
        drive(0, 1, 0, 0, 0, 0);
        chk_done("done_sticky", 1'b1);
        drive(0, 0, 0, 1, 1, 1);
        chk_done("done_cleared_by_load", 1'b0);
`endif

        // Serial fill from reset
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        chk("fill1", 3'b100);
        drive(0, 1, 1, 0, 0, 0);
        chk("fill2", 3'b110);
        drive(0, 1, 0, 0, 0, 0);
        chk("fill3", 3'b011);

        // Reload after a partial shift
        drive(0, 0, 0, 1, 0, 1);
        drive(0, 1, 1, 0, 0, 0);
        chk("partial_shift", 3'b110);
        drive(0, 0, 0, 0, 1, 1);
        chk("reload011", 3'b011);

        // Reset wins over shift
        drive(1, 1, 1, 1, 1, 1);
        chk("rst_over_shift", 3'b000);

        // Randomized traffic, checked by the compare process
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 15) == 0), $urandom_range(0, 2) != 0,
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
